// File: rtl/nubus_pkg.sv
// nubus_pkg: shared states, status codes and transfer decode helpers for the NuBus slave
package nubus_pkg;
  typedef enum logic [1:0] {IDLE, DATA, BEAT, ACK} state_t;
  localparam logic [1:0] STAT_COMPLETE = 2'b00;
  localparam logic [1:0] STAT_ERROR    = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT  = 2'b10;
  localparam logic [1:0] STAT_RETRY    = 2'b11;
  function automatic logic [3:0] byte_lanes(input logic tm0, input logic [1:0] a);
    return !tm0 ? 4'b0001 << a : a == 2'b10 ? 4'b1100 : a == 2'b11 ? 4'b0011 : 4'b1111;
  endfunction
  function automatic logic [4:0] block_beats(input logic [3:0] code);
    return code == 4'b0001 ? 5'd2 : code == 4'b0011 ? 5'd4 : code == 4'b0111 ? 5'd8 :
           code == 4'b1111 ? 5'd16 : 5'd0;
  endfunction
endpackage

// File: rtl/nubus_slave_ctrl_if.sv
// nubus_slave_ctrl_if: NuBus pad, memory handshake and slave status signals
interface nubus_slave_ctrl_if #(parameter int LOCAL_WINDOWS = 2);
  logic [3:0] nub_idn;
  logic [31:0] nub_adn;
  logic nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
  logic mem_ready, mem_error;
  logic slv_slave_o, slv_req_o, slv_write_o;
  logic [31:0] slv_addr_o;
  logic [3:0] slv_bytesel_o;
  logic [LOCAL_WINDOWS+1:0] slv_win_o;
  logic slv_beatn_o, slv_ackcyn_o;
  logic [1:0] slv_stat_o;
  modport slave (
    input nub_idn, nub_adn, nub_startn, nub_ackn, nub_tm1n, nub_tm0n, mem_ready, mem_error,
    output slv_slave_o, slv_req_o, slv_write_o, slv_addr_o, slv_bytesel_o, slv_win_o,
    slv_beatn_o, slv_ackcyn_o, slv_stat_o
  );
  modport master (
    output nub_idn, nub_adn, nub_startn, nub_ackn, nub_tm1n, nub_tm0n, mem_ready, mem_error,
    input slv_slave_o, slv_req_o, slv_write_o, slv_addr_o, slv_bytesel_o, slv_win_o,
    slv_beatn_o, slv_ackcyn_o, slv_stat_o
  );
endinterface

// File: rtl/nubus_slave_decode.sv
// nubus_slave_decode: one-hot window hit, slot over superslot over lowest local window
module nubus_slave_decode #(
  parameter logic [3:0] SLOTS_ADDRESS = 4'hF,
  parameter logic [3:0] SUPERSLOTS_ADDRESS = 4'h9,
  parameter int LOCAL_WINDOWS = 2,
  parameter logic [4*LOCAL_WINDOWS-1:0] LOCAL_START = {4'h0, 4'h6},
  parameter logic [4*LOCAL_WINDOWS-1:0] LOCAL_END = {4'h5, 4'h7}
) (
  input  logic [7:0] top,
  input  logic [3:0] id,
  output logic [LOCAL_WINDOWS+1:0] win
);
  logic std_hit, super_hit;
  assign std_hit = top[7:4] == SLOTS_ADDRESS && top[3:0] == id;
  assign super_hit = top[7:4] >= SUPERSLOTS_ADDRESS && top[7:4] != SLOTS_ADDRESS && top[7:4] == id;
  always_comb begin
    win = '0;
    for (int i = LOCAL_WINDOWS - 1; i >= 0; i--)
      if (top[7:4] >= LOCAL_START[4*(LOCAL_WINDOWS-1-i) +: 4] && top[7:4] <= LOCAL_END[4*(LOCAL_WINDOWS-1-i) +: 4]) begin
        win = '0;
        win[2+i] = 1'b1;
      end
    if (super_hit) win = (LOCAL_WINDOWS+2)'(2'b10);
    if (std_hit) win = (LOCAL_WINDOWS+2)'(2'b01);
  end
endmodule

// File: rtl/nubus_slave_ctrl.sv
// nubus_slave_ctrl: NuBus slave transfer controller; multi-beat block transfers enabled by NUBUS_SLAVE_BLOCK_EN
module nubus_slave_ctrl
  import nubus_pkg::*;
#(
  parameter logic [3:0] SLOTS_ADDRESS = 4'hF,
  parameter logic [3:0] SUPERSLOTS_ADDRESS = 4'h9,
  parameter int LOCAL_WINDOWS = 2,
  parameter logic [4*LOCAL_WINDOWS-1:0] LOCAL_START = {4'h0, 4'h6},
  parameter logic [4*LOCAL_WINDOWS-1:0] LOCAL_END = {4'h5, 4'h7},
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic nub_clkn,
  input logic reset,
  nubus_slave_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0] bsel_q, bsel_d;
  logic [LOCAL_WINDOWS+1:0] win_q, win_d, win_in;
  logic write_q, write_d;
  logic [1:0] stat_q, stat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_in;
  logic [1:0] tm_in;
  logic start;
  assign a_in = ~bus.nub_adn;
  assign tm_in = ~{bus.nub_tm1n, bus.nub_tm0n};
  assign start = state_q == IDLE && !bus.nub_startn && bus.nub_ackn;
`ifdef NUBUS_SLAVE_BLOCK_EN
  logic [4:0] left_q, left_d, beats;
  logic [3:0] mask_q, mask_d;
  logic blk;
  assign beats = block_beats(a_in[5:2]);
  assign blk = tm_in[0] && a_in[1:0] == 2'b01;
`endif
  nubus_slave_decode #(
    .SLOTS_ADDRESS(SLOTS_ADDRESS), .SUPERSLOTS_ADDRESS(SUPERSLOTS_ADDRESS),
    .LOCAL_WINDOWS(LOCAL_WINDOWS), .LOCAL_START(LOCAL_START), .LOCAL_END(LOCAL_END)
  ) u_decode (.top(a_in[31:24]), .id(~bus.nub_idn), .win(win_in));
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    bsel_d = bsel_q;
    win_d = win_q;
    write_d = write_q;
    stat_d = stat_q;
    cnt_d = state_q == DATA ? cnt_q + 1'b1 : '0;
`ifdef NUBUS_SLAVE_BLOCK_EN
    left_d = left_q;
    mask_d = mask_q;
`endif
    case (state_q)
      DATA: begin
        if (bus.mem_error) begin
          state_d = ACK;
          stat_d = STAT_ERROR;
        end else if (bus.mem_ready) begin
`ifdef NUBUS_SLAVE_BLOCK_EN
          if (left_q > 5'd1) begin
            state_d = BEAT;
            left_d = left_q - 5'd1;
            addr_d[5:2] = (addr_q[5:2] & ~mask_q) | ((addr_q[5:2] + 4'd1) & mask_q);
          end else begin
            state_d = ACK;
            stat_d = STAT_COMPLETE;
          end
`else
          state_d = ACK;
          stat_d = STAT_COMPLETE;
`endif
        end else if (cnt_q == TO_LAST) begin
          state_d = ACK;
          stat_d = STAT_TIMEOUT;
        end
      end
      BEAT: state_d = DATA;
      ACK: state_d = IDLE;
      default: begin
        if (start && |win_in) begin
          state_d = DATA;
          addr_d = {a_in[31:2], 2'b00};
          bsel_d = byte_lanes(tm_in[0], a_in[1:0]);
          win_d = win_in;
          write_d = tm_in[1];
`ifdef NUBUS_SLAVE_BLOCK_EN
          left_d = 5'd1;
          if (blk) begin
            bsel_d = 4'hF;
            left_d = beats;
            mask_d = beats[3:0] - 4'd1;
            addr_d[5:2] = a_in[5:2] & ~(beats[3:0] - 4'd1);
            if (beats == 5'd0) begin
              state_d = ACK;
              stat_d = STAT_ERROR;
            end
          end
`endif
        end
      end
    endcase
  end
  always_ff @(posedge nub_clkn) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      bsel_q <= '0;
      win_q <= '0;
      write_q <= 1'b0;
      stat_q <= STAT_COMPLETE;
      cnt_q <= '0;
`ifdef NUBUS_SLAVE_BLOCK_EN
      left_q <= '0;
      mask_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      bsel_q <= bsel_d;
      win_q <= win_d;
      write_q <= write_d;
      stat_q <= stat_d;
      cnt_q <= cnt_d;
`ifdef NUBUS_SLAVE_BLOCK_EN
      left_q <= left_d;
      mask_q <= mask_d;
`endif
    end
  end
  assign bus.slv_slave_o = state_q != IDLE;
  assign bus.slv_req_o = state_q == DATA;
  assign bus.slv_write_o = write_q;
  assign bus.slv_addr_o = addr_q;
  assign bus.slv_bytesel_o = bsel_q;
  assign bus.slv_win_o = win_q;
  assign bus.slv_ackcyn_o = state_q != ACK;
  assign bus.slv_stat_o = stat_q;
`ifdef NUBUS_SLAVE_BLOCK_EN
  assign bus.slv_beatn_o = state_q != BEAT;
`else
  assign bus.slv_beatn_o = 1'b1;
`endif
endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// tb_nubus_slave_ctrl: scoreboard bench for the NuBus slave controller
module tb_nubus_slave_ctrl;
  localparam int K_REQ = 0, K_BEAT = 1, K_ACK = 2;
  typedef struct {
    int kind;
    logic [31:0] addr;
    logic [3:0] bsel;
    logic [3:0] win;
    logic wr;
    logic [1:0] stat;
    int cyc;
    int reqlen;
  } ev_t;
  logic clk, reset;
  int total, passed, cyc, req_len, rcnt, beat_idx;
  int resp_delay, err_beat;
  logic resp_on, req_prev;
  ev_t q[$];
  nubus_slave_ctrl_if #(.LOCAL_WINDOWS(2)) bus ();
  nubus_slave_ctrl #(.TIMEOUT_CYCLES(4)) dut (.nub_clkn(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    else passed++;
  endtask
  task automatic push_req(input logic [31:0] a, input logic [3:0] b, input logic [3:0] w, input logic wr);
    ev_t e;
    e = '{K_REQ, a, b, w, wr, 2'b00, 0, 0};
    q.push_back(e);
  endtask
  task automatic push_beat();
    ev_t e;
    e = '{K_BEAT, 32'h0, 4'h0, 4'h0, 1'b0, 2'b00, 0, 0};
    q.push_back(e);
  endtask
  task automatic push_ack(input logic [1:0] s, input int c, input int rl);
    ev_t e;
    e = '{K_ACK, 32'h0, 4'h0, 4'h0, 1'b0, s, c, rl};
    q.push_back(e);
  endtask
  task automatic got(input int k);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", k, e.kind);
      if (e.kind == K_REQ) begin
        chk("req_addr", bus.slv_addr_o, e.addr);
        chk("req_bytesel", {28'h0, bus.slv_bytesel_o}, {28'h0, e.bsel});
        chk("req_win", {28'h0, bus.slv_win_o}, {28'h0, e.win});
        chk("req_write", {31'h0, bus.slv_write_o}, {31'h0, e.wr});
        chk("req_slave", {31'h0, bus.slv_slave_o}, 32'h1);
      end
      if (e.kind == K_ACK) begin
        chk("ack_stat", {30'h0, bus.slv_stat_o}, {30'h0, e.stat});
        chk("ack_slave", {31'h0, bus.slv_slave_o}, 32'h1);
        if (e.cyc != 0) chk("ack_cycle", cyc, e.cyc);
        if (e.reqlen != 0) chk("req_len", req_len, e.reqlen);
      end
    end
  endtask
  initial begin
    req_prev = 1'b0;
    req_len = 0;
    forever begin
      @(negedge clk);
      if (bus.slv_req_o && !req_prev) begin
        req_len = 1;
        got(K_REQ);
      end else if (bus.slv_req_o) req_len++;
      if (!bus.slv_beatn_o) got(K_BEAT);
      if (!bus.slv_ackcyn_o) got(K_ACK);
      req_prev = bus.slv_req_o;
    end
  end
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_error = 1'b0;
    rcnt = 0;
    beat_idx = 0;
    forever begin
      @(negedge clk);
      if (bus.slv_req_o && resp_on) begin
        bus.mem_ready = rcnt == resp_delay;
        bus.mem_error = rcnt == resp_delay && beat_idx == err_beat;
        if (rcnt == resp_delay) beat_idx++;
        rcnt++;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_error = 1'b0;
        rcnt = 0;
      end
      if (!bus.slv_slave_o) beat_idx = 0;
    end
  end
  task automatic start(input logic [31:0] a, input logic tm1, input logic tm0, input logic [3:0] id);
    bus.nub_adn = ~a;
    bus.nub_tm1n = ~tm1;
    bus.nub_tm0n = ~tm0;
    bus.nub_idn = ~id;
    bus.nub_startn = 1'b0;
    @(negedge clk);
    bus.nub_startn = 1'b1;
    bus.nub_adn = '1;
  endtask
  task automatic settle();
    repeat (12) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask
  task automatic check_reset();
    chk("rst_slave", {31'h0, bus.slv_slave_o}, 32'h0);
    chk("rst_req", {31'h0, bus.slv_req_o}, 32'h0);
    chk("rst_write", {31'h0, bus.slv_write_o}, 32'h0);
    chk("rst_addr", bus.slv_addr_o, 32'h0);
    chk("rst_bytesel", {28'h0, bus.slv_bytesel_o}, 32'h0);
    chk("rst_win", {28'h0, bus.slv_win_o}, 32'h0);
    chk("rst_beatn", {31'h0, bus.slv_beatn_o}, 32'h1);
    chk("rst_ackcyn", {31'h0, bus.slv_ackcyn_o}, 32'h1);
    chk("rst_stat", {30'h0, bus.slv_stat_o}, 32'h0);
  endtask
  initial begin
    total = 0;
    passed = 0;
    resp_on = 1'b1;
    resp_delay = 0;
    err_beat = -1;
    bus.nub_idn = ~4'h3;
    bus.nub_adn = '1;
    bus.nub_startn = 1'b1;
    bus.nub_ackn = 1'b1;
    bus.nub_tm1n = 1'b1;
    bus.nub_tm0n = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset();
    reset = 1'b0;
    @(negedge clk);
    resp_delay = 2;
    push_req(32'hF300_0010, 4'hF, 4'b0001, 1'b0);
    push_ack(2'b00, cyc + 4, 3);
    start(32'hF300_0010, 1'b0, 1'b1, 4'h3);
    settle();
    resp_delay = 0;
    push_req(32'h6000_0000, 4'b0100, 4'b1000, 1'b1);
    push_ack(2'b00, cyc + 2, 1);
    start(32'h6000_0002, 1'b1, 1'b0, 4'h3);
    settle();
    push_req(32'hF300_0000, 4'b1100, 4'b0001, 1'b0);
    push_ack(2'b00, cyc + 2, 1);
    start(32'hF300_0002, 1'b0, 1'b1, 4'h3);
    settle();
    push_req(32'hF300_0000, 4'b0011, 4'b0001, 1'b0);
    push_ack(2'b00, cyc + 2, 1);
    start(32'hF300_0003, 1'b0, 1'b1, 4'h3);
    settle();
    push_req(32'h2000_0000, 4'hF, 4'b0100, 1'b0);
    push_ack(2'b00, cyc + 2, 1);
    start(32'h2000_0000, 1'b0, 1'b1, 4'h3);
    settle();
    start(32'h9300_0000, 1'b0, 1'b1, 4'h3);
    chk("super_wrong_id_slave", {31'h0, bus.slv_slave_o}, 32'h0);
    settle();
`ifdef NUBUS_SLAVE_BLOCK_EN
    push_req(32'h9300_0000, 4'hF, 4'b0010, 1'b0);
    push_beat();
    push_req(32'h9300_0004, 4'hF, 4'b0010, 1'b0);
    push_beat();
    push_req(32'h9300_0008, 4'hF, 4'b0010, 1'b0);
    push_beat();
    push_req(32'h9300_000C, 4'hF, 4'b0010, 1'b0);
    push_ack(2'b00, cyc + 8, 1);
    start(32'h9300_000D, 1'b0, 1'b1, 4'h9);
    settle();
    err_beat = 1;
    push_req(32'h9300_0000, 4'hF, 4'b0010, 1'b0);
    push_beat();
    push_req(32'h9300_0004, 4'hF, 4'b0010, 1'b0);
    push_ack(2'b01, cyc + 4, 1);
    start(32'h9300_001D, 1'b0, 1'b1, 4'h9);
    settle();
    err_beat = -1;
    push_ack(2'b01, cyc + 1, 0);
    start(32'h9300_0015, 1'b0, 1'b1, 4'h9);
    settle();
`else
    push_req(32'h9300_000C, 4'hF, 4'b0010, 1'b0);
    push_ack(2'b00, cyc + 2, 1);
    start(32'h9300_000D, 1'b0, 1'b1, 4'h9);
    chk("noblk_beatn", {31'h0, bus.slv_beatn_o}, 32'h1);
    settle();
`endif
    resp_on = 1'b0;
    push_req(32'hF300_0000, 4'hF, 4'b0001, 1'b0);
    push_ack(2'b10, cyc + 5, 4);
    start(32'hF300_0000, 1'b0, 1'b1, 4'h3);
    settle();
    push_req(32'hF300_0020, 4'hF, 4'b0001, 1'b1);
    start(32'hF300_0020, 1'b1, 1'b1, 4'h3);
    reset = 1'b1;
    @(negedge clk);
    check_reset();
    reset = 1'b0;
    @(negedge clk);
    start(32'hF500_0000, 1'b0, 1'b1, 4'h3);
    chk("miss_slave", {31'h0, bus.slv_slave_o}, 32'h0);
    chk("miss_req", {31'h0, bus.slv_req_o}, 32'h0);
    settle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
